// File: rtl/ncm_pkg.sv
// Shared types and constants for the multi-channel NLFSR challenge engine.
package ncm_pkg;

  // Mix phase length is MIX_MULT * CW NLFSR steps.
  localparam int unsigned MIX_MULT = 2;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StGuard,
    StMix,
    StFlush,
    StEval,
    StWait,
    StOut,
    StDone
  } ncm_state_e;

  typedef struct packed {
    int unsigned a;
    int unsigned b;
    int unsigned c;
  } ncm_taps_t;

  // Feedback taps per register width; 56 is the characterised width.
  function automatic ncm_taps_t ncm_taps(input int unsigned cw);
    ncm_taps_t t;
    if (cw == 56) begin
      t.a = 38;
      t.b = 19;
      t.c = 7;
    end else begin
      t.a = (cw * 2) / 3;
      t.b = cw / 3;
      t.c = cw / 8;
    end
    return t;
  endfunction

endpackage

// File: rtl/ncm_nlfsr_p.sv
// Nonlinear feedback shift register: parallel load has priority over stepping.
module ncm_nlfsr_p
  import ncm_pkg::*;
#(
  parameter int unsigned CW = 56
) (
  input  logic          clkr,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [CW-1:0] data,
  output logic [CW-1:0] state
);

  localparam ncm_taps_t   Taps = ncm_taps(CW);
  localparam int unsigned TapA = Taps.a;
  localparam int unsigned TapB = Taps.b;
  localparam int unsigned TapC = Taps.c;

  logic [CW-1:0] s_q, s_d;
  logic          fb;

  // Next state: load, step or hold.
  always_comb begin
    fb  = s_q[CW-1] ^ s_q[TapA] ^ (s_q[TapB] & s_q[TapC]);
    s_d = s_q;
    if (load) begin
      s_d = data;
    end else if (step) begin
      s_d = {s_q[CW-2:0], fb};
    end
  end

  // State register, cleared on reset.
  always_ff @(posedge clkr or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign state = s_q;

endmodule

// File: rtl/ncm_engine.sv
// Multi-channel PUF challenge engine: seeds/whitens an NLFSR, drives PUF channels
// through arm/ready/done and majority-votes each channel over repeated evaluations.
// Optional build macro NCM_ENGINE_STABILITY_EN enables per-channel unanimity flags
// and the unstable-response tally (unstable_cnt).
module ncm_engine
  import ncm_pkg::*;
#(
  parameter int unsigned CW   = 56,
  parameter int unsigned NPUF = 2,
  parameter int unsigned RPTW = 4,
  parameter int unsigned CNTW = 8
) (
  input  logic            clkr,
  input  logic            rst_n,
  input  logic            i_go,
  input  logic [CW-1:0]   i_seed,
  input  logic [CW-1:0]   i_key,
  input  logic [CNTW-1:0] i_grd,
  input  logic [RPTW-1:0] i_rpt,
  input  logic [CNTW-1:0] i_chx,
  output logic [CW-1:0]   o_puf_chl,
  output logic            o_puf_arm,
  input  logic            i_puf_ready,
  input  logic            i_puf_done,
  input  logic [NPUF-1:0] i_puf_q,
  output logic [NPUF-1:0] o_resp,
  output logic [NPUF-1:0] o_stable,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_done,
  output logic [CW-1:0]   o_state
);

  localparam int unsigned MixLen = MIX_MULT * CW;
  localparam int unsigned MixW   = $clog2(MixLen) + 1;
  localparam int unsigned CycW   = (MixW > CNTW) ? MixW : CNTW;

  localparam logic signed [RPTW:0] AccOne  = 1;
  localparam logic signed [RPTW:0] AccZero = 0;

  ncm_state_e             state_q, state_d;
  logic [CycW-1:0]        cyc_q, cyc_d;
  logic [RPTW-1:0]        rpt_q, rpt_d;
  logic [CNTW-1:0]        run_q, run_d;
  logic                   arm_q, arm_d;
  logic signed [RPTW:0]   accm_q [NPUF];
  logic signed [RPTW:0]   accm_d [NPUF];
  logic                   nl_load, nl_step;
  logic [CW-1:0]          nl_state;
  logic [RPTW-1:0]        rpt_max;
  logic [CNTW-1:0]        chx_max;

  assign rpt_max = (i_rpt == '0) ? RPTW'(1) : i_rpt;
  assign chx_max = (i_chx == '0) ? CNTW'(1) : i_chx;

  ncm_nlfsr_p #(
    .CW(CW)
  ) u_nlfsr (
    .clkr  (clkr),
    .rst_n (rst_n),
    .load  (nl_load),
    .step  (nl_step),
    .data  (i_seed ^ i_key),
    .state (nl_state)
  );

  // Sequencer next-state, counters and vote accumulation.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    rpt_d   = rpt_q;
    run_d   = run_q;
    arm_d   = arm_q;
    accm_d  = accm_q;
    nl_load = 1'b0;
    nl_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_go) state_d = StLoad;
      end
      StLoad: begin
        nl_load = 1'b1;
        cyc_d   = '0;
        run_d   = '0;
        state_d = (i_grd == '0) ? StMix : StGuard;
      end
      StGuard: begin
        nl_step = 1'b1;
        if ((cyc_q + CycW'(1)) == CycW'(i_grd)) begin
          cyc_d   = '0;
          state_d = StMix;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StMix: begin
        nl_step = 1'b1;
        if (cyc_q == CycW'(MixLen - 1)) begin
          cyc_d   = '0;
          state_d = StFlush;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StFlush: begin
        nl_step = 1'b1;
        rpt_d   = '0;
        for (int unsigned k = 0; k < NPUF; k++) accm_d[k] = AccZero;
        if (cyc_q == CycW'(CW - 1)) begin
          cyc_d   = '0;
          state_d = StEval;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StEval: begin
        if (i_puf_ready) begin
          arm_d   = 1'b1;
          rpt_d   = rpt_q + RPTW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_puf_done) begin
          arm_d = 1'b0;
          for (int unsigned k = 0; k < NPUF; k++) begin
            accm_d[k] = i_puf_q[k] ? (accm_q[k] + AccOne) : (accm_q[k] - AccOne);
          end
          state_d = (rpt_q == rpt_max) ? StOut : StEval;
        end
      end
      StOut: begin
        if (i_ready) begin
          run_d   = run_q + CNTW'(1);
          state_d = ((run_q + CNTW'(1)) == chx_max) ? StDone : StFlush;
        end
      end
      StDone: begin
        if (!i_go) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort: drop to idle, keep NLFSR contents.
    if (!i_go && (state_q != StIdle) && (state_q != StDone)) begin
      state_d = StIdle;
      arm_d   = 1'b0;
      nl_load = 1'b0;
      nl_step = 1'b0;
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clkr or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      rpt_q   <= '0;
      run_q   <= '0;
      arm_q   <= 1'b0;
      for (int unsigned k = 0; k < NPUF; k++) accm_q[k] <= AccZero;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      rpt_q   <= rpt_d;
      run_q   <= run_d;
      arm_q   <= arm_d;
      accm_q  <= accm_d;
    end
  end

  // Majority decision per channel; a tie resolves to 0.
  always_comb begin
    o_resp = '0;
    for (int unsigned k = 0; k < NPUF; k++) o_resp[k] = (accm_q[k] > AccZero);
  end

  assign o_puf_chl = nl_state;
  assign o_state   = nl_state;
  assign o_puf_arm = arm_q;
  assign o_valid   = (state_q == StOut);
  assign o_done    = (state_q == StDone);

`ifdef NCM_ENGINE_STABILITY_EN
  logic [NPUF-1:0]  stable;
  logic [RPTW:0]    mag;
  logic [CNTW-1:0]  unstable_cnt, unstable_cnt_d;

  // Unanimity: every evaluation agreed, so |accm| equals the repeat count.
  always_comb begin
    stable = '0;
    mag    = '0;
    for (int unsigned k = 0; k < NPUF; k++) begin
      mag       = (accm_q[k] < AccZero) ? (AccZero - accm_q[k]) : accm_q[k];
      stable[k] = (mag == {1'b0, rpt_max});
    end
  end

  // Saturating tally of accepted responses with any non-unanimous channel.
  always_comb begin
    unstable_cnt_d = unstable_cnt;
    if (state_q == StLoad) begin
      unstable_cnt_d = '0;
    end else if ((state_q == StOut) && i_go && i_ready && !(&stable) &&
                 (unstable_cnt != '1)) begin
      unstable_cnt_d = unstable_cnt + CNTW'(1);
    end
  end

  // Tally register.
  always_ff @(posedge clkr or negedge rst_n) begin
    if (!rst_n) begin
      unstable_cnt <= '0;
    end else begin
      unstable_cnt <= unstable_cnt_d;
    end
  end

  assign o_stable = stable;
`else
  assign o_stable = '1;
`endif

endmodule

// File: tb/tb_ncm_engine.sv
// Directed self-checking bench for ncm_engine with a fixed-latency PUF array model.
module tb_ncm_engine;
  import ncm_pkg::*;

  localparam int unsigned CW   = 56;
  localparam int unsigned NPUF = 2;
  localparam int unsigned RPTW = 4;
  localparam int unsigned CNTW = 8;
  localparam int          LAT  = 8;

`ifdef NCM_ENGINE_STABILITY_EN
  localparam logic [1:0] StabRst   = 2'b00;
  localparam logic [1:0] StabMixed = 2'b00;
`else
  localparam logic [1:0] StabRst   = 2'b11;
  localparam logic [1:0] StabMixed = 2'b11;
`endif

  logic            clkr = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_go = 1'b0;
  logic [CW-1:0]   i_seed = '0;
  logic [CW-1:0]   i_key = '0;
  logic [CNTW-1:0] i_grd = '0;
  logic [RPTW-1:0] i_rpt = '0;
  logic [CNTW-1:0] i_chx = '0;
  logic [CW-1:0]   o_puf_chl, o_state;
  logic            o_puf_arm;
  logic            i_puf_ready = 1'b1;
  logic            i_puf_done = 1'b0;
  logic [NPUF-1:0] i_puf_q = '0;
  logic [NPUF-1:0] o_resp, o_stable;
  logic            o_valid, o_done;
  logic            i_ready = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int q_idx = 0;
  int arm_cnt = 0;
  logic [1:0] q_tab [8];

  ncm_engine #(
    .CW  (CW),
    .NPUF(NPUF),
    .RPTW(RPTW),
    .CNTW(CNTW)
  ) dut (
    .clkr       (clkr),
    .rst_n      (rst_n),
    .i_go       (i_go),
    .i_seed     (i_seed),
    .i_key      (i_key),
    .i_grd      (i_grd),
    .i_rpt      (i_rpt),
    .i_chx      (i_chx),
    .o_puf_chl  (o_puf_chl),
    .o_puf_arm  (o_puf_arm),
    .i_puf_ready(i_puf_ready),
    .i_puf_done (i_puf_done),
    .i_puf_q    (i_puf_q),
    .o_resp     (o_resp),
    .o_stable   (o_stable),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_done     (o_done),
    .o_state    (o_state)
  );

  always #5 clkr = ~clkr;

  // PUF array model: done pulses one cycle, LAT cycles after arm rises.
  initial begin
    forever begin
      @(posedge clkr);
      #1;
      if (i_puf_done) begin
        i_puf_done = 1'b0;
        arm_cnt    = 0;
      end else if (o_puf_arm) begin
        if (arm_cnt == LAT) begin
          i_puf_done = 1'b1;
          i_puf_q    = q_tab[q_idx % 8];
          q_idx++;
        end
        arm_cnt++;
      end else begin
        arm_cnt = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] g_step(input logic [CW-1:0] s, input int n);
    logic [CW-1:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[CW-2:0], r[55] ^ r[38] ^ (r[19] & r[7])};
    return r;
  endfunction

  task automatic tick();
    @(posedge clkr);
    #1;
    cyc++;
  endtask

  task automatic start_run(input logic [CW-1:0] seed, input logic [CW-1:0] key,
                           input int grd, input int rpt, input int chx);
    i_seed = seed;
    i_key  = key;
    i_grd  = CNTW'(grd);
    i_rpt  = RPTW'(rpt);
    i_chx  = CNTW'(chx);
    q_idx  = 0;
    i_go   = 1'b1;
    cyc    = 0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else n_pass++;
    n_checks++; if (o_done !== 1'b0) $display("FAIL reset_done got %b want 0", o_done); else n_pass++;
    n_checks++; if (o_puf_arm !== 1'b0) $display("FAIL reset_arm got %b want 0", o_puf_arm); else n_pass++;
    n_checks++; if (o_resp !== 2'b00) $display("FAIL reset_resp got %b want 00", o_resp); else n_pass++;
    n_checks++; if (o_state !== '0 || o_puf_chl !== '0) $display("FAIL reset_state got %h/%h want 0", o_state, o_puf_chl); else n_pass++;
    n_checks++; if (o_stable !== StabRst) $display("FAIL reset_stable got %b want %b", o_stable, StabRst); else n_pass++;
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++; if (dut.state_q !== StIdle) $display("FAIL reset_idle got %0d want %0d", dut.state_q, StIdle); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    logic [CW-1:0] seed = 56'h0123456789ABCD;
    logic [CW-1:0] key  = 56'h00FEDCBA987654;
    for (int i = 0; i < 8; i++) q_tab[i] = 2'b10;
    i_ready = 1'b1;
    start_run(seed, key, 0, 1, 1);
    wait_valid(ok);
    n_checks++; if (!ok || cyc != 180) $display("FAIL single_valid_cycle got %0d (ok=%0d) want 180", cyc, ok); else n_pass++;
    n_checks++; if (o_resp !== 2'b10) $display("FAIL single_resp got %b want 10", o_resp); else n_pass++;
    n_checks++; if (o_stable !== 2'b11) $display("FAIL single_stable got %b want 11", o_stable); else n_pass++;
    n_checks++; if (o_puf_chl !== g_step(seed ^ key, 168)) $display("FAIL single_chl got %h want %h", o_puf_chl, g_step(seed ^ key, 168)); else n_pass++;
    tick();
    n_checks++; if (o_valid !== 1'b0 || o_done !== 1'b1) $display("FAIL single_done got v=%b d=%b want v=0 d=1", o_valid, o_done); else n_pass++;
    i_go = 1'b0;
    tick();
    n_checks++; if (o_done !== 1'b0) $display("FAIL single_done_clear got %b want 0", o_done); else n_pass++;
  endtask

  task automatic test_vote();
    bit ok;
    q_tab[0] = 2'b11; q_tab[1] = 2'b11; q_tab[2] = 2'b10; q_tab[3] = 2'b00;
    i_ready = 1'b1;
    start_run(56'hA5A5_0000_FFFF_11, 56'h0F0F_1234_0000_EE, 5, 4, 1);
    wait_valid(ok);
    n_checks++; if (!ok || cyc != 215) $display("FAIL vote_valid_cycle got %0d (ok=%0d) want 215", cyc, ok); else n_pass++;
    n_checks++; if (o_resp !== 2'b10) $display("FAIL vote_resp got %b want 10", o_resp); else n_pass++;
    n_checks++; if (o_stable !== StabMixed) $display("FAIL vote_stable got %b want %b", o_stable, StabMixed); else n_pass++;
    n_checks++; if (dut.accm_q[0] !== 5'sd0 || dut.accm_q[1] !== 5'sd2) $display("FAIL vote_accm got %0d/%0d want 0/2", dut.accm_q[0], dut.accm_q[1]); else n_pass++;
    tick();
    i_go = 1'b0;
    tick();
  endtask

  task automatic test_unanimous();
    bit ok;
    for (int i = 0; i < 8; i++) q_tab[i] = 2'b11;
    i_ready = 1'b1;
    start_run(56'h1111_2222_3333_44, 56'h5555_6666_7777_88, 0, 5, 1);
    wait_valid(ok);
    n_checks++; if (!ok || cyc != 220) $display("FAIL unan_valid_cycle got %0d (ok=%0d) want 220", cyc, ok); else n_pass++;
    n_checks++; if (o_resp !== 2'b11) $display("FAIL unan_resp got %b want 11", o_resp); else n_pass++;
    n_checks++; if (o_stable !== 2'b11) $display("FAIL unan_stable got %b want 11", o_stable); else n_pass++;
    n_checks++; if (dut.accm_q[0] !== 5'sd5 || dut.accm_q[1] !== 5'sd5) $display("FAIL unan_accm got %0d/%0d want 5/5", dut.accm_q[0], dut.accm_q[1]); else n_pass++;
    tick();
    i_go = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit frozen;
    int extra;
    logic [CW-1:0] seed = 56'hDEAD_BEEF_0000_01;
    logic [CW-1:0] key  = 56'h0000_CAFE_F00D_02;
    logic [CW-1:0] g;
    q_tab[0] = 2'b01; q_tab[1] = 2'b10; q_tab[2] = 2'b11;
    i_ready = 1'b0;
    start_run(seed, key, 3, 1, 3);
    g = g_step(seed ^ key, 3 + 168);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      n_checks++; if (!ok) $display("FAIL b2b_valid_%0d got timeout want o_valid", k); else n_pass++;
      n_checks++; if (o_puf_chl !== g) $display("FAIL b2b_chl_%0d got %h want %h", k, o_puf_chl, g); else n_pass++;
      n_checks++; if (o_resp !== q_tab[k]) $display("FAIL b2b_resp_%0d got %b want %b", k, o_resp, q_tab[k]); else n_pass++;
      frozen = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (o_valid !== 1'b1 || o_resp !== q_tab[k] || o_state !== g) frozen = 1'b0;
      end
      n_checks++; if (!frozen) $display("FAIL b2b_hold_%0d got change want frozen v=1 resp=%b", k, q_tab[k]); else n_pass++;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      n_checks++; if (o_valid !== 1'b0) $display("FAIL b2b_accept_%0d got v=%b want 0", k, o_valid); else n_pass++;
      g = g_step(g, 56);
    end
    n_checks++; if (o_done !== 1'b1) $display("FAIL b2b_done got %b want 1", o_done); else n_pass++;
    extra = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_valid) extra++;
    end
    n_checks++; if (extra != 0 || o_done !== 1'b1) $display("FAIL b2b_count got extra=%0d done=%b want 0/1", extra, o_done); else n_pass++;
    i_go = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    logic [CW-1:0] seed = 56'h0246_8ACE_1357_9B;
    logic [CW-1:0] key  = 56'h00FF_00FF_00FF_00;
    for (int i = 0; i < 8; i++) q_tab[i] = 2'b10;
    i_ready = 1'b1;
    start_run(seed, key, 0, 1, 1);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (o_puf_arm) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok || cyc != 171) $display("FAIL abort_arm_cycle got %0d (ok=%0d) want 171", cyc, ok); else n_pass++;
    i_go = 1'b0;
    tick();
    n_checks++; if (o_puf_arm !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) $display("FAIL abort_outputs got a=%b v=%b d=%b want 0", o_puf_arm, o_valid, o_done); else n_pass++;
    n_checks++; if (dut.state_q !== StIdle) $display("FAIL abort_idle got %0d want %0d", dut.state_q, StIdle); else n_pass++;
    n_checks++; if (o_state !== g_step(seed ^ key, 168)) $display("FAIL abort_retain got %h want %h", o_state, g_step(seed ^ key, 168)); else n_pass++;
    tick();
    tick();
    start_run(seed, key, 0, 0, 0);
    wait_valid(ok);
    n_checks++; if (!ok || cyc != 180) $display("FAIL restart_valid_cycle got %0d (ok=%0d) want 180", cyc, ok); else n_pass++;
    n_checks++; if (o_resp !== 2'b10 || o_puf_chl !== g_step(seed ^ key, 168)) $display("FAIL restart_resp got %b/%h want 10/%h", o_resp, o_puf_chl, g_step(seed ^ key, 168)); else n_pass++;
    tick();
    n_checks++; if (o_done !== 1'b1 || o_valid !== 1'b0) $display("FAIL restart_done got d=%b v=%b want d=1 v=0", o_done, o_valid); else n_pass++;
    i_go = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_out();
    bit ok;
    for (int i = 0; i < 8; i++) q_tab[i] = 2'b11;
    i_ready = 1'b0;
    start_run(56'h7777_0000_1111_22, 56'h0000_3333_4444_55, 0, 1, 1);
    wait_valid(ok);
    n_checks++; if (!ok) $display("FAIL rstout_valid got timeout want o_valid"); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0 || o_done !== 1'b0 || o_puf_arm !== 1'b0) $display("FAIL rstout_ctrl got v=%b d=%b a=%b want 0", o_valid, o_done, o_puf_arm); else n_pass++;
    n_checks++; if (o_resp !== 2'b00) $display("FAIL rstout_resp got %b want 00", o_resp); else n_pass++;
    n_checks++; if (o_state !== '0 || o_puf_chl !== '0) $display("FAIL rstout_state got %h/%h want 0", o_state, o_puf_chl); else n_pass++;
    n_checks++; if (o_stable !== StabRst) $display("FAIL rstout_stable got %b want %b", o_stable, StabRst); else n_pass++;
    i_go = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (dut.state_q !== StIdle) $display("FAIL rstout_idle got %0d want %0d", dut.state_q, StIdle); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) q_tab[i] = 2'b00;
    test_reset();
    test_single();
    test_vote();
    test_unanimous();
    test_back_to_back();
    test_abort();
    test_reset_in_out();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
